scaled_frame_packer: RTL
========================

// Module: scaled_frame_packer
// PURPOSE
//  Downstream of the 2:1 bilinear image scaler. Takes its gappy output pixel strobes (de_in/i_pixel),
//  converts them to RGB565, packs two pixels per 32-bit word and buffers the words in a FIFO.
//  Emits fixed-length addressed write bursts to the frame-buffer writer, ping-ponging between two frame buffers.
// PARAMETERS
//  DST_W       320  scaled pixels per line; must be a multiple of 2*BURST_LEN
//  DST_H       360  scaled lines per frame
//  FIFO_DEPTH  64   word FIFO depth, power of 2, >= 2*BURST_LEN
//  BURST_LEN   16   32-bit words per burst
//  ADDR_W      20   word-address width; FRAME_WORDS = DST_W*DST_H/2 (57600 with the defaults)
// PORTS
//  pixclk_in   in   1       pixel clock; all logic on its rising edge
//  rst_n       in   1       reset: synchronous, active-low
//  vs_in       in   1       frame sync level; its rising edge marks a new frame
//  de_in       in   1       input pixel valid strobe, one pixel per high cycle, any gaps
//  i_pixel     in   24      {R8,G8,B8}, sampled when de_in=1
//  o_valid     out  1       burst beat valid
//  o_ready     in   1       downstream accepts the beat when o_valid & o_ready
//  o_data      out  32      {pixel(2k+1),pixel(2k)}, RGB565 each
//  o_last      out  1       high on the final beat of each burst
//  o_addr      out  ADDR_W  word address of the current burst's first beat; stable for the whole burst
//  o_buf_sel   out  1       frame buffer currently being written (0/1)
//  frame_done  out  1       one-cycle pulse after the last beat of a frame is accepted
//  overflow    out  1       sticky: a word was dropped because the FIFO was full
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; pair phase 0; state IDLE; all counters 0.
//  Convert: rgb565 = {R[7:3],G[7:2],B[7:3]}.
//  Packing
//   - Even pixel is stored into the low half.
//   - Odd pixel completes the word, which is pushed next cycle (1-cycle latency).
//  Frame limit: pixels beyond DST_W*DST_H in a frame are ignored.
//  FIFO
//   - Synchronous, first-word-fall-through: o_data = head word.
//   - Push is allowed if not full, or if a pop occurs in the same cycle; otherwise the word is dropped and overflow=1.
//   - Simultaneous push+pop leaves the count unchanged.
//  FSM
//   - IDLE: when fifo_count >= BURST_LEN -> BURST, with o_valid=1 from the next cycle.
//   - BURST: beat counter 0..BURST_LEN-1 advances only on o_valid&o_ready; o_last = (beat==BURST_LEN-1).
//   - While o_ready=0: o_valid, o_data, o_last and o_addr are held.
//   - After the last beat is accepted: o_valid=0, return to IDLE (at least one idle cycle between bursts), o_addr += BURST_LEN.
//   - The FIFO never underflows, because BURST starts only when BURST_LEN words are present.
//  Addressing: o_addr = o_buf_sel*FRAME_WORDS + frame word offset.
//  End of frame
//   - On acceptance of beat FRAME_WORDS-1: frame_done pulses, o_buf_sel toggles, offset resets to 0.
//   - o_addr becomes the base of the new buffer.
//  vs_in rising edge (registered edge detect)
//   - Sets frame_pending.
//   - Flush happens immediately if IDLE, otherwise when the current burst completes. A burst is never truncated.
//   - Flush: FIFO emptied, pair phase cleared (a half word is discarded), pixel count and offset zeroed,
//     overflow cleared, o_addr = current buffer base.
//   - o_buf_sel is not toggled by the flush, so a partial frame is rewritten into the same buffer.
//   - de_in is ignored while frame_pending=1.
//  Coincident events
//   - Rising edge on the same cycle as the last frame beat: frame_done/toggle first, then flush of the new buffer.
//   - rst_n=0 mid-burst: outputs return to reset values on the next edge, without completing the burst.
// TESTING
//  1 Hold rst_n=0 for 4 clks -> o_valid, o_last, o_addr, o_buf_sel, frame_done, overflow all 0.
//  2 One 320-pixel line, alternating 0xFF0000, 0x0000FF, o_ready=1 -> 160 beats of 0x001FF800;
//    10 bursts at o_addr 0,16,...,144; o_last on every 16th beat.
//  3 o_ready=0, feed 140 pairs -> FIFO holds 64; overflow=1; o_valid stays high with o_data and o_addr unchanged.
//  4 Full 320x360 frame, o_ready=1 -> frame_done pulses exactly once, after beat 57599;
//    o_buf_sel goes 0->1; next burst o_addr=57600.
//  5 vs_in rise during beat 5 of a burst -> all 16 beats still delivered; FIFO then empty;
//    next burst o_addr = current buffer base; overflow=0.
//  6 Odd pixel count (41) then vs_in rise -> the dangling half word is never emitted;
//    the first word of the new frame contains pixels 0 and 1 of that frame.

Source files
------------

// File: rtl/scaled_frame_packer.sv
// ---------------------------------------------------------------------------
// scaled_frame_packer
//
// Sits behind the 2:1 bilinear scaler. Converts each scaled pixel to RGB565,
// packs pixel pairs into 32-bit words (even pixel in the low half), buffers
// the words in a first-word-fall-through FIFO and drains them as fixed-length
// addressed bursts to the frame-buffer writer, ping-ponging between two
// frame buffers. A rising edge on vs_in restarts the frame: once no burst is
// in flight, buffered data and any half-packed word are discarded and
// addressing returns to the base of the current buffer.
//
// Ports
//   pixclk_in   pixel clock, everything on its rising edge
//   rst_n       synchronous active-low reset
//   vs_in       frame sync level, rising edge starts a new frame
//   de_in       pixel strobe, i_pixel {R8,G8,B8} sampled when high
//   o_valid     burst beat valid
//   o_ready     downstream accepts the beat when o_valid & o_ready
//   o_data      {pixel(2k+1), pixel(2k)} in RGB565
//   o_last      final beat of a burst
//   o_addr      word address of the current burst's first beat
//   o_buf_sel   frame buffer being written
//   frame_done  one-cycle pulse after the last beat of a frame is accepted
//   overflow    sticky, a word was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module scaled_frame_packer #(
    parameter int DST_W      = 320,
    parameter int DST_H      = 360,
    parameter int FIFO_DEPTH = 64,
    parameter int BURST_LEN  = 16,
    parameter int ADDR_W     = 20
) (
    input  logic              pixclk_in,
    input  logic              rst_n,
    input  logic              vs_in,
    input  logic              de_in,
    input  logic [23:0]       i_pixel,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [31:0]       o_data,
    output logic              o_last,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_buf_sel,
    output logic              frame_done,
    output logic              overflow
);

    localparam int FRAME_PIX   = DST_W * DST_H;
    localparam int FRAME_WORDS = FRAME_PIX / 2;
    localparam int PTR_W       = $clog2(FIFO_DEPTH);
    localparam int CNT_W       = PTR_W + 1;
    localparam int PIX_W       = $clog2(FRAME_PIX + 1);
    localparam int BEAT_W      = $clog2(BURST_LEN);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic              vsPrev_q;
    logic              pending_q, pending_d;
    logic              phase_q, phase_d;
    logic [15:0]       half_q, half_d;
    logic [31:0]       word_q, word_d;
    logic              wordValid_q, wordValid_d;
    logic [PIX_W-1:0]  pixCount_q, pixCount_d;
    logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [ADDR_W-1:0] offset_q, offset_d;
    logic              bufSel_q, bufSel_d;
    logic              frameDone_q, frameDone_d;
    logic              overflow_q, overflow_d;

    logic [31:0]       mem [FIFO_DEPTH];

    logic [15:0]       rgb565;
    logic              vsRise;
    logic              pop;
    logic              lastAccept;
    logic              flush;
    logic              pixAccept;
    logic              pushOk;
    logic              unusedPixBits;

    // The low bits of each colour channel are truncated by the RGB565 format.
    assign rgb565        = {i_pixel[23:19], i_pixel[15:10], i_pixel[7:3]};
    assign unusedPixBits = ^{i_pixel[18:16], i_pixel[9:8], i_pixel[2:0]};

    // Flush waits for IDLE so that a burst already started is never truncated.
    // A packed word may still enter a full FIFO when the head leaves in the
    // same cycle.
    assign vsRise     = vs_in & ~vsPrev_q;
    assign pop        = (state_q == BURST) & o_ready;
    assign lastAccept = pop & (beat_q == BEAT_W'(BURST_LEN - 1));
    assign flush      = (state_q == IDLE) & pending_q;
    assign pixAccept  = de_in & ~pending_q & (pixCount_q < PIX_W'(FRAME_PIX));
    assign pushOk     = wordValid_q & ((count_q != CNT_W'(FIFO_DEPTH)) | pop);

    // A pending frame restart takes priority over starting a new burst.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!pending_q && (count_q >= CNT_W'(BURST_LEN))) state_d = BURST;
            BURST:   if (lastAccept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The frame ends exactly on a burst boundary, so the end-of-frame test
    // only needs to look at the offset when a burst's last beat is accepted.
    always_comb begin
        pending_d   = vsRise | (pending_q & ~flush);
        phase_d     = phase_q;
        half_d      = half_q;
        word_d      = word_q;
        wordValid_d = 1'b0;
        pixCount_d  = pixCount_q;
        wrPtr_d     = wrPtr_q + PTR_W'(pushOk);
        rdPtr_d     = rdPtr_q + PTR_W'(pop);
        count_d     = count_q + CNT_W'(pushOk) - CNT_W'(pop);
        overflow_d  = overflow_q | (wordValid_q & ~pushOk);
        beat_d      = beat_q;
        offset_d    = offset_q;
        bufSel_d    = bufSel_q;
        frameDone_d = 1'b0;

        if (pixAccept) begin
            pixCount_d = pixCount_q + PIX_W'(1);
            if (phase_q) begin
                word_d      = {rgb565, half_q};
                wordValid_d = 1'b1;
                phase_d     = 1'b0;
            end else begin
                half_d  = rgb565;
                phase_d = 1'b1;
            end
        end

        if (pop) begin
            if (lastAccept) begin
                beat_d = '0;
                if (offset_q == ADDR_W'(FRAME_WORDS - BURST_LEN)) begin
                    offset_d    = '0;
                    bufSel_d    = ~bufSel_q;
                    frameDone_d = 1'b1;
                end else begin
                    offset_d = offset_q + ADDR_W'(BURST_LEN);
                end
            end else begin
                beat_d = beat_q + BEAT_W'(1);
            end
        end

        if (flush) begin
            phase_d     = 1'b0;
            wordValid_d = 1'b0;
            pixCount_d  = '0;
            wrPtr_d     = '0;
            rdPtr_d     = '0;
            count_d     = '0;
            offset_d    = '0;
            overflow_d  = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge pixclk_in) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Datapath registers; everything returns to zero under reset.
    always_ff @(posedge pixclk_in) begin
        if (!rst_n) begin
            vsPrev_q    <= 1'b0;
            pending_q   <= 1'b0;
            phase_q     <= 1'b0;
            half_q      <= '0;
            word_q      <= '0;
            wordValid_q <= 1'b0;
            pixCount_q  <= '0;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            beat_q      <= '0;
            offset_q    <= '0;
            bufSel_q    <= 1'b0;
            frameDone_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            vsPrev_q    <= vs_in;
            pending_q   <= pending_d;
            phase_q     <= phase_d;
            half_q      <= half_d;
            word_q      <= word_d;
            wordValid_q <= wordValid_d;
            pixCount_q  <= pixCount_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            beat_q      <= beat_d;
            offset_q    <= offset_d;
            bufSel_q    <= bufSel_d;
            frameDone_q <= frameDone_d;
            overflow_q  <= overflow_d;
        end
    end

    // FIFO storage has no reset; occupancy is tracked by the pointers.
    always_ff @(posedge pixclk_in) begin
        if (pushOk) mem[wrPtr_q] <= word_q;
    end

    assign o_valid    = (state_q == BURST);
    assign o_data     = o_valid ? mem[rdPtr_q] : 32'h0;
    assign o_last     = o_valid & (beat_q == BEAT_W'(BURST_LEN - 1));
    assign o_addr     = bufSel_q ? (ADDR_W'(FRAME_WORDS) + offset_q) : offset_q;
    assign o_buf_sel  = bufSel_q;
    assign frame_done = frameDone_q;
    assign overflow   = overflow_q;

endmodule
